// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser: FSM states, command codes,
// default framing bytes and the command-validity helper.
package uart_cmd_parser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_PAY0 = 3'd2,
    ST_PAY1 = 3'd3,
    ST_PAY2 = 3'd4,
    ST_CHK  = 3'd5,
    ST_RESP = 3'd6
  } state_t;

  localparam logic [7:0] CMD_TEMPO_UP   = 8'h01;
  localparam logic [7:0] CMD_TEMPO_DOWN = 8'h02;
  localparam logic [7:0] CMD_PLAY_PAUSE = 8'h03;
  localparam logic [7:0] CMD_REVERSE    = 8'h04;
  localparam logic [7:0] CMD_SET_TONE   = 8'h10;
  localparam logic [7:0] CMD_CLR_TONE   = 8'h11;

  localparam logic [7:0] DEF_SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] DEF_ACK_BYTE   = 8'h06;
  localparam logic [7:0] DEF_NAK_BYTE   = 8'h15;

  function automatic logic cmd_known(input logic [7:0] code);
    case (code)
      CMD_TEMPO_UP, CMD_TEMPO_DOWN, CMD_PLAY_PAUSE, CMD_REVERSE,
      CMD_SET_TONE, CMD_CLR_TONE: cmd_known = 1'b1;
      default:                    cmd_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_parser_frame_timeout.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and
// saturates at TIMEOUT_CYCLES, where expired is raised.
module uart_cmd_parser_frame_timeout #(
  parameter int TIMEOUT_CYCLES = 1_250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes SYNC/CMD/payload/CHK frames from the UART receiver into control
// pulses and a tone override, answering each complete frame with ACK or NAK.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int         CLOCK_FREQ     = 125_000_000,
  parameter int         TIMEOUT_CYCLES = 1_250_000,
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter logic [7:0] ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0] NAK_BYTE       = DEF_NAK_BYTE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tempo_up,
  output logic        tempo_down,
  output logic        play_pause,
  output logic        reverse,
  output logic [23:0] tone_override,
  output logic        tone_override_valid
);

  // A non-positive clock frequency is treated as "no real time base" and
  // disables the inter-byte timeout altogether.
  localparam bit TIMER_ON = (CLOCK_FREQ > 0);

  state_t      state;
  logic [7:0]  cmd;
  logic [7:0]  acc;
  logic [23:0] payload;
  logic        rx_fire;
  logic        tx_fire;
  logic        in_frame;
  logic        expired;
  logic        chk_good;

  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;
  assign in_frame = (state != ST_IDLE) && (state != ST_RESP);
  assign chk_good = (rx_data == acc) && cmd_known(cmd);

  uart_cmd_parser_frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (rx_fire || !in_frame),
    .enable (in_frame && TIMER_ON),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      cmd                 <= 8'h00;
      acc                 <= 8'h00;
      payload             <= 24'h0;
      rx_ready            <= 1'b1;
      tx_data             <= 8'h00;
      tx_valid            <= 1'b0;
      tempo_up            <= 1'b0;
      tempo_down          <= 1'b0;
      play_pause          <= 1'b0;
      reverse             <= 1'b0;
      tone_override       <= 24'h0;
      tone_override_valid <= 1'b0;
    end else begin
      tempo_up   <= 1'b0;
      tempo_down <= 1'b0;
      play_pause <= 1'b0;
      reverse    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (rx_fire && (rx_data == SYNC_BYTE)) begin
            acc   <= 8'h00;
            state <= ST_CMD;
          end
        end

        ST_CMD, ST_PAY0, ST_PAY1, ST_PAY2, ST_CHK: begin
          // Timeout wins over a byte arriving in the same cycle; that byte is lost.
          if (expired) begin
            state <= ST_IDLE;
          end else if (rx_fire) begin
            case (state)
              ST_CMD: begin
                cmd   <= rx_data;
                acc   <= rx_data;
                state <= (rx_data == CMD_SET_TONE) ? ST_PAY0 : ST_CHK;
              end
              ST_PAY0, ST_PAY1, ST_PAY2: begin
                payload <= {payload[15:0], rx_data};
                acc     <= acc ^ rx_data;
                state   <= (state == ST_PAY2) ? ST_CHK : state_t'(state + 3'd1);
              end
              default: begin
                tx_data  <= chk_good ? ACK_BYTE : NAK_BYTE;
                tx_valid <= 1'b1;
                rx_ready <= 1'b0;
                state    <= ST_RESP;
                if (chk_good) begin
                  case (cmd)
                    CMD_TEMPO_UP:   tempo_up   <= 1'b1;
                    CMD_TEMPO_DOWN: tempo_down <= 1'b1;
                    CMD_PLAY_PAUSE: play_pause <= 1'b1;
                    CMD_REVERSE:    reverse    <= 1'b1;
                    CMD_SET_TONE: begin
                      tone_override       <= payload;
                      tone_override_valid <= 1'b1;
                    end
                    CMD_CLR_TONE:   tone_override_valid <= 1'b0;
                    default: ;
                  endcase
                end
              end
            endcase
          end
        end

        ST_RESP: begin
          if (tx_fire) begin
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end

        default: begin
          state    <= ST_IDLE;
          rx_ready <= 1'b1;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed and randomized frames against a frame-level reference model of
// the command parser (checksum, command table, tone override state).
module tb_uart_cmd_parser;

  localparam int T = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tempo_up, tempo_down, play_pause, reverse;
  logic [23:0] tone_override;
  logic        tone_override_valid;
  logic [3:0]  pv;

  int          vectors = 0;
  int          errors  = 0;
  logic [23:0] m_tone  = 24'h0;
  logic        m_valid = 1'b0;
  logic [7:0]  cmd_tbl [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11};

  always #5 clk = ~clk;
  assign pv = {reverse, play_pause, tempo_down, tempo_up};

  uart_cmd_parser #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rx_data            (rx_data),
    .rx_valid           (rx_valid),
    .rx_ready           (rx_ready),
    .tx_data            (tx_data),
    .tx_valid           (tx_valid),
    .tx_ready           (tx_ready),
    .tempo_up           (tempo_up),
    .tempo_down         (tempo_down),
    .play_pause         (play_pause),
    .reverse            (reverse),
    .tone_override      (tone_override),
    .tone_override_valid(tone_override_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic known(input logic [7:0] c);
    return (c >= 8'h01 && c <= 8'h04) || c == 8'h10 || c == 8'h11;
  endfunction

  function automatic logic [3:0] pulse_of(input logic [7:0] c);
    if (c >= 8'h01 && c <= 8'h04) return 4'b0001 << (c - 8'h01);
    return 4'b0000;
  endfunction

  task automatic check_tone();
    chk("tone_override", {8'h0, tone_override}, {8'h0, m_tone});
    chk("tone_valid", {31'h0, tone_override_valid}, {31'h0, m_valid});
  endtask

  // One byte per call; returns on the negedge right after the accepting edge.
  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    chk("rx_ready_idle", {31'h0, rx_ready}, 32'h1);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("no_tx_valid", {31'h0, tx_valid}, 32'h0);
      chk("no_pulse", {28'h0, pv}, 32'h0);
    end
    check_tone();
  endtask

  task automatic expect_resp(input logic [7:0] resp, input logic [3:0] pulses, input int hold);
    chk("tx_valid_resp", {31'h0, tx_valid}, 32'h1);
    chk("tx_data_resp", {24'h0, tx_data}, {24'h0, resp});
    chk("pulse_resp", {28'h0, pv}, {28'h0, pulses});
    chk("rx_ready_resp", {31'h0, rx_ready}, 32'h0);
    check_tone();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("tx_valid_hold", {31'h0, tx_valid}, 32'h1);
      chk("tx_data_hold", {24'h0, tx_data}, {24'h0, resp});
      chk("pulse_hold", {28'h0, pv}, 32'h0);
      chk("rx_ready_hold", {31'h0, rx_ready}, 32'h0);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    chk("tx_valid_done", {31'h0, tx_valid}, 32'h0);
    chk("pulse_done", {28'h0, pv}, 32'h0);
    chk("rx_ready_done", {31'h0, rx_ready}, 32'h1);
    tx_ready = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] c, input logic [23:0] pay,
                           input logic [7:0] ck, input int hold);
    logic [7:0] x;
    logic       good;
    x = c;
    drive_byte(8'hA5);
    drive_byte(c);
    if (c == 8'h10) begin
      for (int i = 2; i >= 0; i--) begin
        x = x ^ pay[8*i +: 8];
        drive_byte(pay[8*i +: 8]);
      end
    end
    drive_byte(ck);
    good = known(c) && (ck == x);
    if (good && c == 8'h10) begin
      m_tone  = pay;
      m_valid = 1'b1;
    end
    if (good && c == 8'h11) m_valid = 1'b0;
    $display("frame cmd=%02h pay=%06h chk=%02h good=%0d", c, pay, ck, good);
    expect_resp(good ? 8'h06 : 8'h15, good ? pulse_of(c) : 4'b0000, hold);
  endtask

  initial begin
    logic [7:0]  c, ck, junk;
    logic [23:0] pay;

    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    chk("rst_pulses", {28'h0, pv}, 32'h0);
    check_tone();

    // Basic commands, tone set/clear, NAK cases
    run_frame(8'h01, 24'h0, 8'h01, 0);
    drive_byte(8'h33);
    idle_check(2);
    run_frame(8'h10, 24'h001234, 8'h36, 0);
    run_frame(8'h11, 24'h0, 8'h11, 0);
    run_frame(8'h03, 24'h0, 8'h00, 0);
    run_frame(8'h7F, 24'h0, 8'h7F, 1);

    // Timeout mid-payload, then recovery
    drive_byte(8'hA5);
    drive_byte(8'h10);
    drive_byte(8'h00);
    idle_check(T + 3);
    run_frame(8'h04, 24'h0, 8'h04, 0);

    // Last byte one cycle before the timeout is still accepted
    drive_byte(8'hA5);
    drive_byte(8'h01);
    repeat (T - 2) @(negedge clk);
    drive_byte(8'h01);
    expect_resp(8'h06, 4'b0001, 0);

    // Byte landing in the timeout cycle is dropped, no response
    drive_byte(8'hA5);
    drive_byte(8'h01);
    repeat (T - 1) @(negedge clk);
    drive_byte(8'h01);
    idle_check(3);
    run_frame(8'h02, 24'h0, 8'h02, 0);

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        drive_byte(junk);
      end
      c   = ($urandom_range(0, 7) < 6) ? cmd_tbl[$urandom_range(0, 5)] : 8'($urandom);
      pay = 24'($urandom);
      ck  = (c == 8'h10) ? (c ^ pay[23:16] ^ pay[15:8] ^ pay[7:0]) : c;
      if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      run_frame(c, pay, ck, $urandom_range(0, 3));
    end

    // Make sure an override is active before the mid-response reset
    run_frame(8'h10, 24'hABCDEF, 8'h10 ^ 8'hAB ^ 8'hCD ^ 8'hEF, 0);

    // Long backpressure, then reset while responding
    drive_byte(8'hA5);
    drive_byte(8'h02);
    drive_byte(8'h02);
    chk("td_tx_valid", {31'h0, tx_valid}, 32'h1);
    chk("td_tx_data", {24'h0, tx_data}, 32'h06);
    chk("td_pulse", {28'h0, pv}, 32'h2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("td_hold_valid", {31'h0, tx_valid}, 32'h1);
      chk("td_hold_data", {24'h0, tx_data}, 32'h06);
      chk("td_hold_pulse", {28'h0, pv}, 32'h0);
      chk("td_hold_rx_ready", {31'h0, rx_ready}, 32'h0);
    end
    rst_n = 1'b0;
    #1;
    m_tone  = 24'h0;
    m_valid = 1'b0;
    chk("arst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("arst_rx_ready", {31'h0, rx_ready}, 32'h1);
    check_tone();
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(8'h03, 24'h0, 8'h03, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
